// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mole_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    WAIT_HIT,
    HIT,
    MISS,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci feedback taps (x^16 + x^14 + x^13 + x^11 + 1)
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam int SCORE_W = 6;
  localparam int LIVES_W = 2;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR used to pick mole positions; next_value is combinational.
// Latency: value moves to next_value on the edge where advance is high.
// Backpressure: none; holds its value whenever advance is low.
module mole_lfsr
  import mole_game_pkg::*;
(
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        advance,
  output logic [15:0] value,
  output logic [15:0] next_value
);

  assign next_value = lfsr_step(value);

  // Shift register: seeded on reset, steps only when asked
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round controller: mole placement, timing, whack detection, score/lives.
// Latency: switch change sampled at edge k -> HIT/MISS at k+2 -> next mole LED at k+4.
// Backpressure: none; switches are free-running inputs and toggles outside WAIT_HIT are dropped.
module mole_round_sequencer
  import mole_game_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int MOLE_TICKS = 8,
  parameter int MIN_TICKS  = 3,
  parameter int LIVES      = 3,
  parameter int WIN_SCORE  = 32
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          SWITCHES,
  output logic [15:0]          LEDS,
  output logic [SCORE_W-1:0]   score_count,
  output logic [LIVES_W-1:0]   lives_left,
  output logic                 game_over,
  output logic                 win
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TW = 8;

  state_t               state, state_nxt;
  logic [15:0]          s1, s2, prev;
  logic [15:0]          toggle;
  logic [15:0]          mole_mask;
  logic [3:0]           mole, mole_nxt;
  logic [SCORE_W-1:0]   score, score_nxt;
  logic [LIVES_W-1:0]   lives, lives_nxt;
  logic                 win_q, win_nxt;
  logic [TW-1:0]        tcnt, tcnt_nxt;
  logic [TW-1:0]        limit;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic                 advance;
  logic                 wrong_hit, right_hit;
  logic [15:0]          lfsr_value, lfsr_next;
  logic                 unused_lfsr_bits;

  mole_lfsr u_lfsr (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .advance    (advance),
    .value      (lfsr_value),
    .next_value (lfsr_next)
  );

  // Only the low nibble of the next LFSR word selects a mole
  assign unused_lfsr_bits = ^{lfsr_value, lfsr_next[15:4]};

  // Two-flop synchronizer plus a previous-value stage for edge detection
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= SWITCHES;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign toggle    = s2 ^ prev;
  assign mole_mask = 16'd1 << mole;
  assign wrong_hit = |(toggle & ~mole_mask);
  assign right_hit = |(toggle & mole_mask);

  // Game tick prescaler: runs only while a mole is up, restarts at each spawn
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (state == SPAWN) begin
      presc <= '0;
    end else if (state == WAIT_HIT) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  assign tick = (state == WAIT_HIT) && (presc == PW'(TICK_DIV - 1));

  // Mole timeout shrinks by one tick per 8 points, floored at MIN_TICKS
  always_comb begin
    limit = TW'(MOLE_TICKS) - {{(TW-3){1'b0}}, score[5:3]};
    if ({{(TW-3){1'b0}}, score[5:3]} + TW'(MIN_TICKS) > TW'(MOLE_TICKS)) begin
      limit = TW'(MIN_TICKS);
    end
  end

  // State and game registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      score <= '0;
      lives <= LIVES_W'(LIVES);
      win_q <= 1'b0;
      mole  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      score <= score_nxt;
      lives <= lives_nxt;
      win_q <= win_nxt;
      mole  <= mole_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // Next-state, score/lives bookkeeping and LED drive
  always_comb begin
    state_nxt = state;
    score_nxt = score;
    lives_nxt = lives;
    win_nxt   = win_q;
    mole_nxt  = mole;
    tcnt_nxt  = tcnt;
    advance   = 1'b0;
    LEDS      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SPAWN;
          score_nxt = '0;
          lives_nxt = LIVES_W'(LIVES);
        end
      end
      SPAWN: begin
        advance   = 1'b1;
        // Never show the same hole twice in a row
        mole_nxt  = (lfsr_next[3:0] == mole) ? lfsr_next[3:0] + 4'd1 : lfsr_next[3:0];
        tcnt_nxt  = '0;
        state_nxt = WAIT_HIT;
      end
      WAIT_HIT: begin
        LEDS = mole_mask;
        if (wrong_hit) begin
          state_nxt = MISS;
          lives_nxt = lives - LIVES_W'(1);
        end else if (right_hit) begin
          state_nxt = HIT;
          score_nxt = (score == '1) ? score : score + SCORE_W'(1);
        end else if (tick) begin
          if (tcnt == limit - TW'(1)) begin
            state_nxt = MISS;
            lives_nxt = lives - LIVES_W'(1);
          end else begin
            tcnt_nxt = tcnt + TW'(1);
          end
        end
      end
      HIT: begin
        if (score == SCORE_W'(WIN_SCORE)) begin
          state_nxt = DONE;
          win_nxt   = 1'b1;
        end else begin
          state_nxt = SPAWN;
        end
      end
      MISS: begin
        if (lives == '0) begin
          state_nxt = DONE;
          win_nxt   = 1'b0;
        end else begin
          state_nxt = SPAWN;
        end
      end
      DONE: begin
        LEDS = win_q ? 16'hFFFF : 16'h0000;
        if (start) begin
          state_nxt = SPAWN;
          score_nxt = '0;
          lives_nxt = LIVES_W'(LIVES);
          win_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign score_count = score;
  assign lives_left  = lives;
  assign game_over   = (state == DONE);
  assign win         = win_q;

endmodule

// File: tb/tb_mole_round_sequencer.sv
// Randomized scoreboard bench for mole_round_sequencer against a round-level game model.
// Latency: expected events carry the exact cycle on which they must appear.
// Backpressure: n/a.
module tb_mole_round_sequencer;

  localparam int TD = 4;
  localparam int MT = 5;
  localparam int MN = 4;
  localparam int LV = 3;
  localparam int WS = 18;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] SWITCHES;
  logic [15:0] LEDS;
  logic [5:0]  score_count;
  logic [1:0]  lives_left;
  logic        game_over;
  logic        win;

  mole_round_sequencer #(
    .TICK_DIV   (TD),
    .MOLE_TICKS (MT),
    .MIN_TICKS  (MN),
    .LIVES      (LV),
    .WIN_SCORE  (WS)
  ) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .start       (start),
    .SWITCHES    (SWITCHES),
    .LEDS        (LEDS),
    .score_count (score_count),
    .lives_left  (lives_left),
    .game_over   (game_over),
    .win         (win)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] leds;
    int          score;
    int          lives;
    bit          go;
    bit          wn;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pushed = 0;
  int          seen = 0;
  int          last_cyc = 0;
  logic [15:0] last_leds = '0;

  // Reference game model: round-level view of the rules
  int m_lfsr, m_mole, m_score, m_lives;
  bit m_done;

  // Monitor scratch
  logic [15:0] mon_pl = '0;
  bit          mon_pg = 1'b0;
  bit          mon_onehot;
  exp_t        mon_e;

  function automatic int lfsr_next(input int x);
    int fb;
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return ((x << 1) & 32'hFFFF) | fb;
  endfunction

  function automatic int limit_of(input int s);
    int l;
    l = MT - s / 8;
    return (l < MN) ? MN : l;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)", name, cyc, act, act, exp, exp);
    end
  endtask

  task automatic expect_evt(input logic [15:0] l, input int s, input int lv, input bit go, input bit w, input int c);
    exp_t e;
    e.leds = l; e.score = s; e.lives = lv; e.go = go; e.wn = w; e.cyc = c;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic model_reset();
    m_lfsr = 32'hACE1; m_mole = 0; m_score = 0; m_lives = LV; m_done = 0;
  endtask

  task automatic model_spawn();
    int nm;
    m_lfsr = lfsr_next(m_lfsr);
    nm = m_lfsr % 16;
    if (nm == m_mole) nm = (nm + 1) % 16;
    m_mole = nm;
  endtask

  // Outcome of a round resolved at edge a (hit or miss)
  task automatic model_outcome(input bit hit, input int a);
    if (hit) begin
      m_score = (m_score + 1 > 63) ? 63 : m_score + 1;
      if (m_score == WS) begin
        m_done = 1;
        expect_evt(16'hFFFF, m_score, m_lives, 1, 1, a + 1);
      end else begin
        model_spawn();
        expect_evt(16'(1 << m_mole), m_score, m_lives, 0, 0, a + 2);
      end
    end else begin
      m_lives = m_lives - 1;
      if (m_lives == 0) begin
        m_done = 1;
        expect_evt(16'h0000, m_score, 0, 1, 0, a + 1);
      end else begin
        model_spawn();
        expect_evt(16'(1 << m_mole), m_score, m_lives, 0, 0, a + 2);
      end
    end
  endtask

  task automatic next_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_events();
    int g;
    g = 0;
    while (seen < pushed && g < 400) begin
      @(posedge CLK);
      g++;
    end
    if (seen < pushed) begin
      checks++;
      errors++;
      $display("FAIL event_timeout: saw %0d events, expected %0d", seen, pushed);
      sb.delete();
      seen = pushed;
    end
  endtask

  task automatic do_start();
    int j;
    next_edge();
    start = 1'b1;
    j = cyc;
    m_score = 0; m_lives = LV; m_done = 0;
    model_spawn();
    expect_evt(16'(1 << m_mole), 0, LV, 0, 0, j + 2);
    next_edge();
    start = 1'b0;
  endtask

  // kind: 0 correct whack, 1 wrong switch, 2 correct+wrong together, 3 let it time out
  task automatic play_round(input int kind);
    int j, w, a;
    logic [15:0] mask;
    wait_events();
    next_edge();
    if (kind == 3) begin
      a = last_cyc + limit_of(m_score) * TD;
      model_outcome(0, a);
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        next_edge();
        start = 1'b0;
      end
    end else begin
      repeat ($urandom_range(0, 3)) next_edge();
      j = cyc;
      w = (m_mole + $urandom_range(1, 15)) % 16;
      if (kind == 0)      mask = 16'(1 << m_mole);
      else if (kind == 1) mask = 16'(1 << w);
      else                mask = 16'((1 << m_mole) | (1 << w));
      model_outcome(kind == 0, j + 3);
      SWITCHES = SWITCHES ^ mask;
    end
  endtask

  // Edge counter
  initial begin
    forever begin
      @(posedge CLK);
      cyc <= cyc + 1;
    end
  end

  // Monitor: an event is a new one-hot mole or game_over rising
  initial begin
    forever begin
      @(negedge CLK);
      if (!reset_n) begin
        mon_pl = '0;
        mon_pg = 1'b0;
      end else begin
        mon_onehot = (LEDS != 16'h0) && ((LEDS & (LEDS - 16'h1)) == 16'h0);
        if ((game_over && !mon_pg) || (mon_onehot && LEDS != mon_pl)) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event at cycle %0d: LEDS=%h score=%0d lives=%0d", cyc, LEDS, score_count, lives_left);
          end else begin
            mon_e = sb.pop_front();
            check("evt_leds", LEDS, mon_e.leds);
            check("evt_score", score_count, mon_e.score);
            check("evt_lives", lives_left, mon_e.lives);
            check("evt_game_over", game_over, mon_e.go);
            check("evt_win", win, mon_e.wn);
            check("evt_cycle", cyc, mon_e.cyc);
          end
          seen++;
          last_cyc = cyc;
          last_leds = LEDS;
        end
        mon_pl = LEDS;
        mon_pg = game_over;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int kind, r;
    bit win_game;
    reset_n  = 1'b0;
    start    = 1'b0;
    SWITCHES = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_leds", LEDS, 0);
    check("reset_score", score_count, 0);
    check("reset_lives", lives_left, LV);
    check("reset_game_over", game_over, 0);
    check("reset_win", win, 0);
    reset_n = 1'b1;
    repeat (2) next_edge();

    for (int g = 0; g < 4; g++) begin
      win_game = (g % 2 == 0);
      do_start();
      if (g == 0) begin
        wait_events();
        check("first_mole", last_leds, 16'h0008);
      end
      r = 0;
      while (!m_done && r < 40) begin
        if (win_game) begin
          if ((m_score == 9 && m_lives == 3) || (m_score == 16 && m_lives == 2))
            kind = (g == 0) ? 3 : $urandom_range(1, 3);
          else
            kind = 0;
        end else begin
          kind = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(1, 3);
        end
        play_round(kind);
        r++;
      end
      wait_events();
      // Toggles and time in DONE must not disturb the final result
      SWITCHES = SWITCHES ^ 16'($urandom_range(1, 16'hFFFF));
      repeat (6) next_edge();
      check("done_hold_game_over", game_over, 1);
      check("done_hold_score", score_count, m_score);
      check("done_hold_lives", lives_left, m_lives);
      check("done_hold_leds", LEDS, (m_lives != 0) ? 16'hFFFF : 16'h0000);
    end

    // Mid-game asynchronous reset
    do_start();
    play_round(0);
    play_round(0);
    play_round(1);
    wait_events();
    repeat (3) next_edge();
    reset_n = 1'b0;
    #1;
    check("async_reset_leds", LEDS, 0);
    check("async_reset_score", score_count, 0);
    check("async_reset_lives", lives_left, LV);
    check("async_reset_game_over", game_over, 0);
    check("async_reset_win", win, 0);
    repeat (2) next_edge();
    reset_n = 1'b1;
    model_reset();
    repeat (5) next_edge();
    do_start();
    wait_events();
    check("mole_after_reset", last_leds, 16'h0008);
    repeat (3) next_edge();
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
